csa_stream_accumulator: RTL
===========================

# csa_stream_accumulator

Sequential multi-operand adder. It accepts W-bit operands one per handshake, keeps the running total in carry-save (sum/carry vector) form, and resolves the group of N operands to a single binary result with one carry-propagate addition. It sits on the operand side of the datapath and replaces the parallel four-operand carry-save adder wherever operands arrive serially over a valid/ready stream. For W=4, N=4 its result format (out_sum[W:0] plus out_cout) matches the parallel four-operand adder.

## Interface
Parameters:
- W, 4, operand width in bits (2..16).
- N, 4, operands per group (2..4). The result width W+2 is sufficient for every legal N.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  W  unsigned operand.
- out_valid  output  1  result is valid and held stable.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W+1  result bits [W:0].
- out_cout  output  1  result bit [W+1].
- busy  output  1  high when a group is in progress (count≠0) or the block is not in ACCUM.

## Operation
- Internal registers:
  - s, c: carry-save vectors, W+2 bits each.
  - count: 0..N-1.
  - state: ACCUM, RESOLVE or OUTPUT.
  - res: W+2 bits.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready. x is in_data zero-extended to W+2 bits.
  - s <= s^c^x; c <= ((s&c)|(s&x)|(c&x))<<1, truncated to W+2 bits.
  - Accept with count<N-1: count <= count+1.
  - Accept with count==N-1: go to RESOLVE and clear count.
- RESOLVE:
  - Lasts exactly one cycle. in_ready=0.
  - res <= s+c, mod 2^(W+2). Go to OUTPUT.
- OUTPUT:
  - out_valid=1. out_sum=res[W:0], out_cout=res[W+1]. in_ready=0.
  - Outputs are held unchanged until out_valid && out_ready.
  - On that handshake: s, c, count <= 0; go to ACCUM.
- Arithmetic: all values are unsigned. The true sum of N operands is below 2^(W+2), so the result is exact and overflow cannot occur.
- in_valid low in ACCUM: no state change. Gaps between operands are allowed without limit.
- in_valid high while in_ready=0: the operand is ignored, not captured. The source must hold it until it is accepted.
- out_ready high while out_valid=0: no effect.
- Reset, including assertion mid-group or mid-OUTPUT:
  - state=ACCUM; s, c, res, count=0.
  - out_valid=0, out_sum=0, out_cout=0, busy=0.
  - in_ready is forced to 0 while rst is high and becomes 1 in the first cycle after rst deasserts.
  - A partially accumulated group is discarded.

## Timing
- in_ready, out_valid, out_sum, out_cout and busy are driven from registers or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Final operand accepted at edge k: RESOLVE occupies the cycle after edge k, and out_valid rises after edge k+1.
- Output handshake at edge m: in_ready is 1 in the cycle after edge m.
- Minimum period per group with continuous valid/ready is N+2 cycles: N accepts, 1 RESOLVE, 1 OUTPUT.
- Back-to-back groups lose no operand. The first operand of the next group is accepted at edge m+1 at the earliest.

## Test plan
- Reset then the operand groups below, with out_ready=1:
  - {10,0,0,0} -> out_sum=10, out_cout=0.
  - {10,10,0,0} -> out_sum=20, out_cout=0.
  - {4,6,12,0} -> out_sum=22, out_cout=0.
  - {11,2,4,7} -> out_sum=24, out_cout=0.
  - {12,5,10,10} -> out_sum=5, out_cout=1 (37).
  - {15,15,15,15} -> out_sum=28, out_cout=1 (60).
- Latency: the final operand of {7,6,12,8} is accepted at edge k -> out_valid rises after edge k+1 with out_sum=1, out_cout=1 (33). A scoreboard checks the N+2 cycle period with continuous valid/ready.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> outputs stay stable, in_ready=0, and a presented in_data=9 is not captured. Release out_ready, then send {1,1,1,1} -> result is 4.
- Input gaps: {3,_,_,5,_,2,1}, where _ means in_valid=0 -> result 11. busy stays high from the first accept until the output handshake.
- Reset mid-group: accept 15 and 15, pulse rst asynchronously between edges -> all outputs 0 immediately. Then send {1,2,3,4} -> out_sum=10, out_cout=0.
- Parameter sweep: W=4, N=2 with {15,15} -> out_sum=30, out_cout=0. W=8, N=3 with {255,255,255} -> 765, i.e. out_cout=1, out_sum=253.

Source files
------------

// File: rtl/csa_stream_accumulator_if.sv
// Operand/result stream bundle for csa_stream_accumulator.
// The master is the operand source and result sink; the slave is the accumulator.
interface csa_stream_accumulator_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    logic         out_cout;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout
    );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Serial multi-operand adder: operands arrive one per handshake and are folded
// into a carry-save pair; one carry-propagate add resolves each group of N.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ACCUM   | accepting operands, folding each into sum/carry vectors
// ST_RESOLVE | single cycle: carry-propagate add of sum and carry vectors
// ST_OUTPUT  | result presented and held until the downstream accepts it
module csa_stream_accumulator #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    csa_stream_accumulator_if.slave   io_strm,
    output logic                      o_busy
);
    localparam int RW = W + 2;
    localparam logic [1:0] LAST = 2'(N - 1);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [RW-1:0]   r_s;
    logic [RW-1:0]   r_c;
    logic [RW-1:0]   r_res;
    logic [1:0]      r_count;

    logic [RW-1:0]   w_x;
    logic [RW-1:0]   w_maj;
    logic            w_accept;
    logic            w_out_hs;
    logic            w_last;

    assign w_x      = {2'b00, io_strm.in_data};
    assign w_maj    = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
    assign w_accept = (r_state == ST_ACCUM) && io_strm.in_valid;
    assign w_out_hs = (r_state == ST_OUTPUT) && io_strm.out_ready;
    assign w_last   = (r_count == LAST);

    // Next-state decode for the accumulate / resolve / present sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCUM:   if (w_accept && w_last) w_next_state = ST_RESOLVE;
            ST_RESOLVE: w_next_state = ST_OUTPUT;
            ST_OUTPUT:  if (io_strm.out_ready) w_next_state = ST_ACCUM;
            default:    w_next_state = ST_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_ACCUM;
        else       r_state <= w_next_state;
    end

    // Carry-save accumulation, group counter and resolved result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s     <= '0;
            r_c     <= '0;
            r_res   <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_s     <= r_s ^ r_c ^ w_x;
                r_c     <= {w_maj[RW-2:0], 1'b0};
                r_count <= w_last ? 2'd0 : r_count + 2'd1;
            end
            if (r_state == ST_RESOLVE) begin
                r_res <= r_s + r_c;
            end
            if (w_out_hs) begin
                r_s     <= '0;
                r_c     <= '0;
                r_count <= '0;
            end
        end
    end

    // Outputs come only from state and registers; in_ready is also held low
    // while reset is asserted so no operand is taken during reset.
    assign io_strm.in_ready  = (r_state == ST_ACCUM) && !i_rst;
    assign io_strm.out_valid = (r_state == ST_OUTPUT);
    assign io_strm.out_sum   = r_res[W:0];
    assign io_strm.out_cout  = r_res[W+1];
    assign o_busy            = (r_count != 2'd0) || (r_state != ST_ACCUM);

endmodule
